// File: rtl/uart_rx_pkg.sv
// Shared types and reset defaults for the UART receive control block.
package uart_rx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } rx_state_t;

   localparam int ENTRY_W      = 10;
   localparam int CNT_W        = 10;
   localparam int DEF_PRESCALE = 8;
   localparam int DEF_PAR_EN   = 1;
   localparam int DEF_PAR_TYP  = 0;

endpackage

// File: rtl/rx_frame_fifo.sv
// First-word-fall-through frame FIFO with registered head, occupancy count
// and a drop indication for pushes that find the FIFO full without a pop.
module rx_frame_fifo
   import uart_rx_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = ENTRY_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           din,
   output logic [W-1:0]           dout,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] cnt,
   output logic                   drop
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_inc;
   logic          empty;
   logic          full;
   logic          do_push;
   logic          do_pop;
   logic [AW:0]   cnt_nxt;
   logic [W-1:0]  head_nxt;

   assign empty      = (cnt == '0);
   assign full       = (cnt == (AW+1)'(DEPTH));
   assign do_pop     = pop && !empty;
   assign do_push    = push && (!full || do_pop);
   assign drop       = push && full && !pop;
   assign rd_ptr_inc = rd_ptr + AW'(1);

   // The head is kept in its own register so rd_* come straight from flops.
   always_comb begin
      cnt_nxt  = cnt;
      head_nxt = dout;
      if (do_push && !do_pop) begin
         cnt_nxt = cnt + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
         cnt_nxt = cnt - (AW+1)'(1);
      end
      if (cnt_nxt == '0) begin
         head_nxt = '0;
      end else if (do_pop) begin
         head_nxt = (cnt == (AW+1)'(1)) ? din : mem[rd_ptr_inc];
      end else if (empty) begin
         head_nxt = din;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         valid  <= 1'b0;
         dout   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr_inc;
         cnt   <= cnt_nxt;
         valid <= (cnt_nxt != '0);
         dout  <= head_nxt;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: frame activity FSM with timeout, glitch-free
// configuration update between frames, and buffering of completed frames.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | line idle; pending configuration may be applied
//   ST_BUSY | frame in progress; timer running, configuration frozen
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int RST_PRESCALE = DEF_PRESCALE,
   parameter int RST_PAR_EN   = DEF_PAR_EN,
   parameter int RST_PAR_TYP  = DEF_PAR_TYP,
   parameter int FRAME_BITS   = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   RX_IN,
   input  logic                   cfg_wr,
   input  logic [5:0]             cfg_prescale,
   input  logic                   cfg_par_en,
   input  logic                   cfg_par_typ,
   output logic [5:0]             prescale,
   output logic                   PAR_EN,
   output logic                   PAR_TYP,
   output logic                   cfg_pending,
   input  logic [7:0]             P_DATA,
   input  logic                   data_valid,
   input  logic                   stop_err,
   input  logic                   parity_err,
   input  logic                   rd_en,
   output logic [7:0]             rd_data,
   output logic                   rd_stop_err,
   output logic                   rd_par_err,
   output logic                   rd_valid,
   output logic [$clog2(DEPTH):0] fifo_cnt,
   output logic                   overrun,
   input  logic                   ovr_clr,
   output logic                   busy,
   output logic                   timeout
);

   rx_state_t          state;
   rx_state_t          state_nxt;
   logic               rx_q;
   logic               stop_q;
   logic               par_q;
   logic               start_det;
   logic               frame_done;
   logic               apply;
   logic [CNT_W-1:0]   tmr;
   logic [CNT_W-1:0]   tmr_nxt;
   logic [CNT_W-1:0]   tmr_lim;
   logic               timeout_nxt;
   logic [5:0]         eff_pre;
   logic [5:0]         sh_prescale;
   logic               sh_par_en;
   logic               sh_par_typ;
   logic [ENTRY_W-1:0] fifo_head;
   logic               fifo_drop;

   assign start_det  = rx_q & ~RX_IN;
   assign frame_done = data_valid | (stop_err & ~stop_q) | (parity_err & ~par_q);
   assign eff_pre    = (prescale == 6'd0) ? 6'd1 : prescale;
   assign tmr_lim    = CNT_W'(int'(eff_pre) * FRAME_BITS - 1);
   assign apply      = (state == ST_IDLE) && cfg_pending && !start_det;
   assign busy       = (state == ST_BUSY);

   always_comb begin
      state_nxt   = state;
      tmr_nxt     = tmr;
      timeout_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_det) begin
               state_nxt = ST_BUSY;
               tmr_nxt   = '0;
            end
         end
         ST_BUSY: begin
            tmr_nxt = tmr + CNT_W'(1);
            // A frame ending on the limit cycle is a normal end, not a timeout.
            if (frame_done) begin
               state_nxt = ST_IDLE;
            end else if (tmr == tmr_lim) begin
               state_nxt   = ST_IDLE;
               timeout_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         tmr     <= '0;
         timeout <= 1'b0;
         rx_q    <= 1'b1;
         stop_q  <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         tmr     <= tmr_nxt;
         timeout <= timeout_nxt;
         rx_q    <= RX_IN;
         stop_q  <= stop_err;
         par_q   <= parity_err;
      end
   end

   // The apply uses the shadow as it stood before any same-cycle write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_prescale <= 6'(RST_PRESCALE);
         sh_par_en   <= 1'(RST_PAR_EN);
         sh_par_typ  <= 1'(RST_PAR_TYP);
         prescale    <= 6'(RST_PRESCALE);
         PAR_EN      <= 1'(RST_PAR_EN);
         PAR_TYP     <= 1'(RST_PAR_TYP);
         cfg_pending <= 1'b0;
      end else begin
         if (cfg_wr) begin
            sh_prescale <= cfg_prescale;
            sh_par_en   <= cfg_par_en;
            sh_par_typ  <= cfg_par_typ;
         end
         if (apply) begin
            prescale <= sh_prescale;
            PAR_EN   <= sh_par_en;
            PAR_TYP  <= sh_par_typ;
         end
         if (cfg_wr) begin
            cfg_pending <= 1'b1;
         end else if (apply) begin
            cfg_pending <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (fifo_drop) begin
         overrun <= 1'b1;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end
   end

   rx_frame_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (frame_done),
      .pop   (rd_en),
      .din   ({parity_err, stop_err, P_DATA}),
      .dout  (fifo_head),
      .valid (rd_valid),
      .cnt   (fifo_cnt),
      .drop  (fifo_drop)
   );

   assign rd_data     = fifo_head[7:0];
   assign rd_stop_err = fifo_head[8];
   assign rd_par_err  = fifo_head[9];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a queue-based behavioural model.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 4;
   localparam int FRAME_BITS = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic       cfg_wr = 1'b0;
   logic [5:0] cfg_prescale = 6'd0;
   logic       cfg_par_en = 1'b0;
   logic       cfg_par_typ = 1'b0;
   logic [5:0] prescale;
   logic       par_en_o;
   logic       par_typ_o;
   logic       cfg_pending;
   logic [7:0] p_data = 8'd0;
   logic       data_valid = 1'b0;
   logic       stop_err = 1'b0;
   logic       parity_err = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic       rd_stop_err;
   logic       rd_par_err;
   logic       rd_valid;
   logic [2:0] fifo_cnt;
   logic       overrun;
   logic       ovr_clr = 1'b0;
   logic       busy;
   logic       timeout;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .RX_IN        (rx_in),
      .cfg_wr       (cfg_wr),
      .cfg_prescale (cfg_prescale),
      .cfg_par_en   (cfg_par_en),
      .cfg_par_typ  (cfg_par_typ),
      .prescale     (prescale),
      .PAR_EN       (par_en_o),
      .PAR_TYP      (par_typ_o),
      .cfg_pending  (cfg_pending),
      .P_DATA       (p_data),
      .data_valid   (data_valid),
      .stop_err     (stop_err),
      .parity_err   (parity_err),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_stop_err  (rd_stop_err),
      .rd_par_err   (rd_par_err),
      .rd_valid     (rd_valid),
      .fifo_cnt     (fifo_cnt),
      .overrun      (overrun),
      .ovr_clr      (ovr_clr),
      .busy         (busy),
      .timeout      (timeout)
   );

   // Behavioural model state
   logic       m_rxh, m_seh, m_peh;
   logic       m_busy, m_to, m_ovr, m_pend;
   int         m_pres, s_pres, m_age;
   logic       m_par_en, m_par_typ, s_par_en, s_par_typ;
   logic [9:0] q[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rxh = 1'b1; m_seh = 1'b0; m_peh = 1'b0;
      m_busy = 1'b0; m_to = 1'b0; m_ovr = 1'b0; m_pend = 1'b0;
      m_pres = 8; s_pres = 8; m_age = 0;
      m_par_en = 1'b1; s_par_en = 1'b1; m_par_typ = 1'b0; s_par_typ = 1'b0;
      q.delete();
   endtask

   task automatic model_step();
      logic st, dn, popped, dropped;
      int   lim;
      st = m_rxh && !rx_in;
      dn = data_valid || (stop_err && !m_seh) || (parity_err && !m_peh);
      m_rxh = rx_in; m_seh = stop_err; m_peh = parity_err;
      m_to = 1'b0;
      if (!m_busy && m_pend && !st) begin
         m_pres = s_pres; m_par_en = s_par_en; m_par_typ = s_par_typ; m_pend = 1'b0;
      end
      if (cfg_wr) begin
         s_pres = int'(cfg_prescale); s_par_en = cfg_par_en; s_par_typ = cfg_par_typ; m_pend = 1'b1;
      end
      if (!m_busy) begin
         if (st) begin m_busy = 1'b1; m_age = 0; end
      end else begin
         m_age++;
         lim = ((m_pres == 0) ? 1 : m_pres) * FRAME_BITS;
         if (dn) m_busy = 1'b0;
         else if (m_age == lim) begin m_busy = 1'b0; m_to = 1'b1; end
      end
      popped = rd_en && (q.size() > 0);
      if (popped) void'(q.pop_front());
      dropped = 1'b0;
      if (dn) begin
         if (q.size() == DEPTH) dropped = 1'b1;
         else q.push_back({parity_err, stop_err, p_data});
      end
      if (dropped) m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
   endtask

   task automatic compare();
      logic [9:0] h;
      chk("prescale", int'(prescale), m_pres);
      chk("par_en", int'(par_en_o), int'(m_par_en));
      chk("par_typ", int'(par_typ_o), int'(m_par_typ));
      chk("cfg_pending", int'(cfg_pending), int'(m_pend));
      chk("busy", int'(busy), int'(m_busy));
      chk("timeout", int'(timeout), int'(m_to));
      chk("rd_valid", int'(rd_valid), (q.size() > 0) ? 1 : 0);
      chk("fifo_cnt", int'(fifo_cnt), q.size());
      chk("overrun", int'(overrun), int'(m_ovr));
      if (q.size() > 0) begin
         h = q[0];
         chk("rd_data", int'(rd_data), int'(h[7:0]));
         chk("rd_stop_err", int'(rd_stop_err), int'(h[8]));
         chk("rd_par_err", int'(rd_par_err), int'(h[9]));
      end
   endtask

   task automatic tick();
      if (rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic start_edge();
      rx_in = 1'b0; tick(); rx_in = 1'b1;
   endtask

   task automatic check_reset_literals(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_timeout"}, int'(timeout), 0);
      chk({tag, "_prescale"}, int'(prescale), 8);
      chk({tag, "_par_en"}, int'(par_en_o), 1);
      chk({tag, "_par_typ"}, int'(par_typ_o), 0);
      chk({tag, "_pending"}, int'(cfg_pending), 0);
      chk({tag, "_rd_valid"}, int'(rd_valid), 0);
      chk({tag, "_fifo_cnt"}, int'(fifo_cnt), 0);
      chk({tag, "_rd_data"}, int'(rd_data), 0);
      chk({tag, "_rd_flags"}, int'({rd_par_err, rd_stop_err}), 0);
      chk({tag, "_overrun"}, int'(overrun), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic seen;
      model_reset();

      // Reset and first frame
      tick();
      check_reset_literals("rst");
      rst = 1'b0;
      tick();
      start_edge();
      chk("f1_busy", int'(busy), 1);
      tick();
      data_valid = 1'b1; p_data = 8'hA5; tick(); data_valid = 1'b0;
      chk("f1_busy_end", int'(busy), 0);
      chk("f1_rd_valid", int'(rd_valid), 1);
      chk("f1_rd_data", int'(rd_data), 8'hA5);
      chk("f1_flags", int'({rd_par_err, rd_stop_err}), 0);
      chk("f1_cnt", int'(fifo_cnt), 1);

      // Configuration written mid-frame waits for IDLE
      start_edge();
      cfg_wr = 1'b1; cfg_prescale = 6'd16; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
      tick(); cfg_wr = 1'b0;
      repeat (5) tick();
      chk("cfg_hold_prescale", int'(prescale), 8);
      chk("cfg_hold_pending", int'(cfg_pending), 1);
      data_valid = 1'b1; p_data = 8'h11; tick(); data_valid = 1'b0;
      chk("cfg_done_prescale", int'(prescale), 8);
      tick();
      chk("cfg_apply_prescale", int'(prescale), 16);
      chk("cfg_apply_par_en", int'(par_en_o), 0);
      chk("cfg_apply_pending", int'(cfg_pending), 0);
      cfg_wr = 1'b1; cfg_prescale = 6'd8; cfg_par_en = 1'b1; tick(); cfg_wr = 1'b0;
      chk("cfg_lat1_prescale", int'(prescale), 16);
      tick();
      chk("cfg_lat2_prescale", int'(prescale), 8);
      rd_en = 1'b1; repeat (2) tick(); rd_en = 1'b0;

      // Timeout with prescale 8
      start_edge();
      n = 0; seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         tick(); n++;
         if (timeout) seen = 1'b1;
      end
      chk("to_latency", n, 96);
      chk("to_busy", int'(busy), 0);
      chk("to_fifo_cnt", int'(fifo_cnt), 0);
      tick();
      chk("to_pulse_width", int'(timeout), 0);

      // Overrun: five frames into a four-entry FIFO
      for (int i = 1; i <= 5; i++) begin
         start_edge(); tick();
         data_valid = 1'b1; p_data = 8'(i); tick(); data_valid = 1'b0;
         tick();
      end
      chk("ovr_cnt", int'(fifo_cnt), 4);
      chk("ovr_flag", int'(overrun), 1);
      for (int i = 1; i <= 4; i++) begin
         chk("ovr_pop_data", int'(rd_data), i);
         rd_en = 1'b1; tick(); rd_en = 1'b0;
      end
      chk("ovr_empty", int'(rd_valid), 0);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("ovr_clr", int'(overrun), 0);

      // Parity error edge detection
      start_edge(); tick();
      parity_err = 1'b1; p_data = 8'h3C; tick();
      chk("par_data", int'(rd_data), 8'h3C);
      chk("par_flag", int'(rd_par_err), 1);
      chk("par_busy", int'(busy), 0);
      start_edge(); repeat (3) tick();
      chk("par_hold_cnt", int'(fifo_cnt), 1);
      chk("par_hold_busy", int'(busy), 1);
      parity_err = 1'b0; tick();
      parity_err = 1'b1; tick();
      chk("par_rise_cnt", int'(fifo_cnt), 2);
      chk("par_rise_busy", int'(busy), 0);
      parity_err = 1'b0;
      rd_en = 1'b1; repeat (2) tick(); rd_en = 1'b0;

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         data_valid = 1'b1; p_data = 8'(64 + i); tick();
      end
      data_valid = 1'b0;
      chk("full_cnt", int'(fifo_cnt), 4);
      data_valid = 1'b1; p_data = 8'h50; rd_en = 1'b1; tick();
      data_valid = 1'b0; rd_en = 1'b0;
      chk("full_pp_cnt", int'(fifo_cnt), 4);
      chk("full_pp_ovr", int'(overrun), 0);
      chk("full_pp_head", int'(rd_data), 8'h41);

      // Asynchronous reset mid-frame
      start_edge();
      #2; rst = 1'b1; rx_in = 1'b1;
      #1;
      check_reset_literals("arst");
      model_reset();
      @(posedge clk); #1;
      compare();
      rst = 1'b0;
      tick();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rx_in        = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
         data_valid   = ($urandom_range(0, 11) == 0);
         p_data       = 8'($urandom);
         if ($urandom_range(0, 15) == 0) stop_err = ~stop_err;
         if ($urandom_range(0, 15) == 0) parity_err = ~parity_err;
         rd_en        = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
         ovr_clr      = ($urandom_range(0, 29) == 0);
         cfg_wr       = ($urandom_range(0, 24) == 0);
         cfg_prescale = 6'($urandom_range(0, 3));
         cfg_par_en   = 1'($urandom);
         cfg_par_typ  = 1'($urandom);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Control and buffering block between the UART receive datapath and the host side.
- Holds the receiver configuration (prescale, parity enable, parity type) and applies host updates only between frames, so the configuration never changes mid-frame.
- Tracks frame activity on the serial line and aborts a hung frame with a timeout.
- Stores each completed frame (data plus error flags) in a small first-word-fall-through FIFO with overrun detection.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2).
- RST_PRESCALE, 8, prescale value after reset.
- RST_PAR_EN, 1, parity enable after reset.
- RST_PAR_TYP, 0, parity type after reset (0 = even, 1 = odd).
- FRAME_BITS, 12, timeout length in bit periods.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line, same signal the receiver sees, already in the clk domain.
- cfg_wr  in  1  one-cycle strobe that loads the shadow configuration.
- cfg_prescale  in  6  new prescale value.
- cfg_par_en  in  1  new parity enable.
- cfg_par_typ  in  1  new parity type.
- prescale  out  6  active prescale, drives the receiver.
- PAR_EN  out  1  active parity enable, drives the receiver.
- PAR_TYP  out  1  active parity type, drives the receiver.
- cfg_pending  out  1  shadow configuration written but not yet applied.
- P_DATA  in  8  received byte from the receiver.
- data_valid  in  1  frame-good pulse from the receiver.
- stop_err  in  1  stop error from the receiver (level).
- parity_err  in  1  parity error from the receiver (level).
- rd_en  in  1  pop the FIFO head.
- rd_data  out  8  FIFO head data.
- rd_stop_err  out  1  FIFO head stop-error flag.
- rd_par_err  out  1  FIFO head parity-error flag.
- rd_valid  out  1  FIFO not empty.
- fifo_cnt  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky flag: a frame was dropped.
- ovr_clr  in  1  clear the overrun flag.
- busy  out  1  frame in progress.
- timeout  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset (asynchronous):
  - prescale/PAR_EN/PAR_TYP take their RST_* values; the shadow registers take the same values.
  - cfg_pending=0, FSM in IDLE, busy=0, timeout=0.
  - FIFO empty: rd_valid=0, fifo_cnt=0, rd_data=0, rd_stop_err=0, rd_par_err=0; overrun=0.
  - Reset mid-frame or mid-FIFO discards everything.
- Events:
  - start_det = registered RX_IN equals 1 and current RX_IN equals 0 (falling edge). The RX_IN history register resets to 1.
  - frame_done = data_valid OR rising edge of stop_err OR rising edge of parity_err. Error history registers reset to 0.
  - Coincident causes produce one frame_done.
- FSM, two states:
  - IDLE -> BUSY on start_det; the timeout counter clears.
  - BUSY -> IDLE on frame_done.
  - BUSY -> IDLE when the counter reaches prescale*FRAME_BITS-1; timeout pulses for one cycle on that transition.
  - If frame_done and the timeout limit occur in the same cycle, frame_done wins and there is no timeout pulse.
  - busy = (state == BUSY).
  - Counter: 10 bits, increments each BUSY cycle. prescale=0 is treated as 1.
- Configuration:
  - cfg_wr loads the shadow registers and sets cfg_pending. A later cfg_wr while pending overwrites the shadow (last write wins).
  - At a clock edge where state==IDLE, cfg_pending=1 and start_det=0: active <= shadow, cfg_pending <= 0.
  - Minimum latency from cfg_wr to the active outputs is 2 cycles.
  - cfg_wr in the same cycle as an apply: the apply uses the old shadow, the new shadow is loaded, and cfg_pending stays 1.
  - The active configuration never changes while busy=1.
- FIFO:
  - Push on frame_done in any state. The entry is {parity_err, stop_err, P_DATA} sampled in that cycle.
  - First-word fall-through: the rd_* outputs show the head while rd_valid=1.
  - rd_en while empty: ignored.
  - Push while full without a pop: the frame is dropped, contents are unchanged, and overrun is set.
  - Push and pop in the same cycle while full: both happen, count is unchanged, no overrun.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo DEPTH.
  - ovr_clr clears overrun; if a set and ovr_clr occur in the same cycle, the set wins.
- All outputs are registered.

Decomposition:
- Package uart_rx_pkg holds: the FSM state encoding, the FIFO entry width constant (10), and the RST_* defaults.
- One sub-module, rx_frame_fifo: synchronous FWFT FIFO with count and an overflow-drop indication. The FSM, configuration shadow and timeout counter stay in the top module.

Test Plan:
- Reset, then drive a frame: RX_IN falling edge -> busy=1; data_valid with P_DATA=0xA5 -> busy=0, rd_valid=1, rd_data=0xA5, flags 0, fifo_cnt=1.
- cfg_wr (prescale=16, PAR_EN=0) while busy=1 -> prescale stays 8 and cfg_pending=1 until frame_done; 1 cycle after IDLE, prescale=16, PAR_EN=0, cfg_pending=0.
- Start edge with no frame_done, prescale=8 -> timeout pulses exactly 96 cycles after busy rises, busy=0, FIFO unchanged.
- Frames 0x01..0x05 with no reads, DEPTH=4 -> fifo_cnt=4, overrun=1, pops return 0x01..0x04, 0x05 is lost; ovr_clr -> overrun=0.
- parity_err rises together with P_DATA=0x3C -> entry rd_data=0x3C, rd_par_err=1; parity_err held high for the next frame gives no extra push until it falls and rises again.
- FIFO full, push and rd_en in the same cycle -> fifo_cnt stays 4, no overrun, head advances; assert rst mid-frame -> all outputs return to reset values immediately.
